// File: rtl/decoder_quiz_pkg.sv
// Shared definitions for the decoder quiz sequencers: FSM state encoding,
// the default decoder width and a counter-sizing helper.
package decoder_quiz_pkg;

  localparam int unsigned DEF_IN_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Number of bits needed to hold any value in 0..value (never less than 1).
  function automatic int unsigned clog2_w(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) <= 64'(value)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/quiz_settle_timer.sv
// Loadable down-counter used to hold each quiz code stable before compare.
// zero flags an empty count; last flags that the current decrement empties it.
module quiz_settle_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: a load wins over a decrement; the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/decoder_quiz_sequencer.sv
// Sweeps every input code into a golden and a student 2^IN_W-line decoder,
// compares their outputs per code, counts mismatches and reports pass/fail.
module decoder_quiz_sequencer
  import decoder_quiz_pkg::*;
#(
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned LOOPS      = 1,
  parameter int unsigned ERR_W      = 8,
  localparam int unsigned OUT_W     = 1 << IN_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  a,
  input  logic [OUT_W-1:0] b_true,
  input  logic [OUT_W-1:0] b_test,
  output logic             busy,
  output logic             check_res,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [IN_W-1:0]  first_err_code
);

  localparam int unsigned SET_W  = clog2_w(SETTLE_CYC);
  localparam int unsigned LOOP_W = clog2_w(LOOPS);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
  // With no settle time a code is compared in the cycle right after it is driven.
  localparam state_e ENTRY_ST = (SETTLE_CYC == 0) ? ST_CHECK : ST_SETTLE;

  state_e             state_d, state_q;
  logic [IN_W-1:0]    a_d, a_q;
  logic               busy_d, busy_q;
  logic               check_res_d, check_res_q;
  logic               done_d, done_q;
  logic               pass_d, pass_q;
  logic [ERR_W-1:0]   err_cnt_d, err_cnt_q;
  logic               fev_d, fev_q;
  logic [IN_W-1:0]    fec_d, fec_q;
  logic [LOOP_W-1:0]  loop_d, loop_q;

  logic tmr_load, tmr_dec, tmr_zero, tmr_last;
  logic codes_match;

  assign codes_match = (b_true == b_test);

  quiz_settle_timer #(.CNT_W(SET_W)) u_settle_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (tmr_load),
    .load_val  (SET_W'(SETTLE_CYC)),
    .dec       (tmr_dec),
    .zero      (tmr_zero),
    .last      (tmr_last)
  );

  // Sequencer next-state and output logic; abort overrides everything.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d     = state_q;
    a_d         = a_q;
    busy_d      = busy_q;
    check_res_d = check_res_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fev_d       = fev_q;
    fec_d       = fec_q;
    loop_d      = loop_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      a_d     = '0;
      loop_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // The done cycle still belongs to the finishing run, so start is held off.
          if (start && !done_q) begin
            state_d   = ENTRY_ST;
            a_d       = '0;
            busy_d    = 1'b1;
            err_cnt_d = '0;
            fev_d     = 1'b0;
            pass_d    = 1'b0;
            loop_d    = '0;
            tmr_load  = 1'b1;
          end
        end
        ST_SETTLE: begin
          tmr_dec = 1'b1;
          if (tmr_last || tmr_zero) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          check_res_d = codes_match;
          if (!codes_match) begin
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (!fev_q) begin
              fev_d = 1'b1;
              fec_d = a_q;
            end
          end
          if ((a_q == '1) && (loop_q == LOOP_LAST)) begin
            state_d = ST_FINISH;
          end else begin
            a_d      = a_q + IN_W'(1);
            if (a_q == '1) loop_d = loop_q + LOOP_W'(1);
            tmr_load = 1'b1;
            state_d  = ENTRY_ST;
          end
        end
        ST_FINISH: begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == '0);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      busy_q      <= 1'b0;
      check_res_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fev_q       <= 1'b0;
      fec_q       <= '0;
      loop_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      busy_q      <= busy_d;
      check_res_q <= check_res_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fev_q       <= fev_d;
      fec_q       <= fec_d;
      loop_q      <= loop_d;
    end
  end

  assign a               = a_q;
  assign busy            = busy_q;
  assign check_res       = check_res_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_code  = fec_q;

endmodule

// File: tb/tb_decoder_quiz_sequencer.sv
// Bench for decoder_quiz_sequencer. Two instances: d=0 (SETTLE_CYC=2, LOOPS=1,
// ERR_W=8) and d=1 (SETTLE_CYC=0, LOOPS=2, ERR_W=2). A per-code fault table
// decides where the student decoder is wrong; expectations come from that table.
module tb_decoder_quiz_sequencer;

  localparam int IN_W  = 2;
  localparam int OUT_W = 4;
  localparam int NCODE = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  logic [1:0]            start = '0;
  logic [1:0]            abort = '0;
  logic [1:0][IN_W-1:0]  a;
  logic [1:0][OUT_W-1:0] b_true, b_test;
  logic [1:0]            busy, check_res, done, pass, fev;
  logic [1:0][IN_W-1:0]  fec;
  logic [1:0][7:0]       err_cnt;
  logic [7:0]            err_cnt_a;
  logic [1:0]            err_cnt_b;
  logic [1:0][NCODE-1:0] bad = '0;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  // Golden decoder on both inputs; the student decoder inverts its output on faulty codes.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      b_true[d] = OUT_W'(1) << a[d];
      b_test[d] = bad[d][a[d]] ? ~b_true[d] : b_true[d];
    end
  end

  assign err_cnt[0] = err_cnt_a;
  assign err_cnt[1] = {6'd0, err_cnt_b};

  decoder_quiz_sequencer #(.IN_W(2), .SETTLE_CYC(2), .LOOPS(1), .ERR_W(8)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start[0]), .abort(abort[0]),
    .a(a[0]), .b_true(b_true[0]), .b_test(b_test[0]), .busy(busy[0]),
    .check_res(check_res[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt_a),
    .first_err_valid(fev[0]), .first_err_code(fec[0])
  );

  decoder_quiz_sequencer #(.IN_W(2), .SETTLE_CYC(0), .LOOPS(2), .ERR_W(2)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start[1]), .abort(abort[1]),
    .a(a[1]), .b_true(b_true[1]), .b_test(b_test[1]), .busy(busy[1]),
    .check_res(check_res[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt_b),
    .first_err_valid(fev[1]), .first_err_code(fec[1])
  );

  function automatic int settle_of(input int d); return (d == 0) ? 2 : 0; endfunction
  function automatic int loops_of(input int d);  return (d == 0) ? 1 : 2; endfunction
  function automatic int errmax_of(input int d); return (d == 0) ? 255 : 3; endfunction

  // One full run with reference-model expectations; optional second start pulse mid-run.
  task automatic run_and_check(input int d, input int restart_at, input string tag);
    int exp_seq[$];
    int seen[$];
    int e_err, e_first, e_busy, n_bad;
    int busy_cycles, done_cycles, done_cyc, last_busy_cyc, budget;
    bit seq_ok;
    int prev_a;

    n_bad = 0;
    e_first = -1;
    for (int c = 0; c < NCODE; c++) begin
      if (bad[d][c]) begin
        n_bad++;
        if (e_first < 0) e_first = c;
      end
    end
    for (int l = 0; l < loops_of(d); l++)
      for (int c = 0; c < NCODE; c++) exp_seq.push_back(c);
    e_err  = n_bad * loops_of(d);
    if (e_err > errmax_of(d)) e_err = errmax_of(d);
    e_busy = loops_of(d) * NCODE * (settle_of(d) + 1) + 1;
    budget = e_busy + 4;

    start[d] = 1'b1;
    @(negedge sys_clk);
    start[d] = 1'b0;
    busy_cycles = 0; done_cycles = 0; done_cyc = -1; last_busy_cyc = -1; prev_a = -1;

    for (int cyc = 0; cyc < budget; cyc++) begin
      if (busy[d]) begin
        busy_cycles++;
        last_busy_cyc = cyc;
        if (seen.size() == 0 || int'(a[d]) != prev_a) begin
          if (seen.size() > 0) begin
            checks++;
            if (check_res[d] !== !bad[d][prev_a]) begin
              errors++;
              $display("FAIL %s check_res after code %0d: got %b want %b", tag, prev_a,
                       check_res[d], !bad[d][prev_a]);
            end
          end
          seen.push_back(int'(a[d]));
        end
        prev_a = int'(a[d]);
      end
      if (done[d]) begin
        done_cycles++;
        done_cyc = cyc;
        if (prev_a >= 0) begin
          checks++;
          if (check_res[d] !== !bad[d][prev_a]) begin
            errors++;
            $display("FAIL %s check_res last code %0d: got %b want %b", tag, prev_a,
                     check_res[d], !bad[d][prev_a]);
          end
        end
      end
      start[d] = (cyc == restart_at);
      @(negedge sys_clk);
    end
    start[d] = 1'b0;

    checks++;
    if (busy_cycles != e_busy) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", tag, busy_cycles, e_busy);
    end
    checks++;
    if (done_cycles != 1 || done_cyc != last_busy_cyc + 1) begin
      errors++;
      $display("FAIL %s done_pulse: got %0d pulses at cycle %0d want 1 at cycle %0d", tag,
               done_cycles, done_cyc, last_busy_cyc + 1);
    end
    seq_ok = (seen.size() == exp_seq.size());
    for (int i = 0; i < seen.size() && seq_ok; i++) seq_ok = (seen[i] == exp_seq[i]);
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL %s a_sequence: got %0d codes want %0d codes in order 0..%0d x%0d", tag,
               seen.size(), exp_seq.size(), NCODE - 1, loops_of(d));
    end
    checks++;
    if (pass[d] !== (e_err == 0)) begin
      errors++;
      $display("FAIL %s pass: got %b want %b", tag, pass[d], (e_err == 0));
    end
    checks++;
    if (err_cnt[d] !== 8'(e_err)) begin
      errors++;
      $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt[d], e_err);
    end
    checks++;
    if (fev[d] !== (n_bad > 0)) begin
      errors++;
      $display("FAIL %s first_err_valid: got %b want %b", tag, fev[d], (n_bad > 0));
    end
    if (n_bad > 0) begin
      checks++;
      if (int'(fec[d]) != e_first) begin
        errors++;
        $display("FAIL %s first_err_code: got %0d want %0d", tag, fec[d], e_first);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({a[d], busy[d], check_res[d], done[d], pass[d], err_cnt[d], fev[d], fec[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got a=%0d busy=%b done=%b err=%0d want all 0",
                 d, a[d], busy[d], done[d], err_cnt[d]);
      end
    end
    #2 sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (busy !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: busy got %b want 00", busy);
    end
  endtask

  task automatic test_clean_sweep();
    bad[0] = '0;
    run_and_check(0, -1, "clean_sweep");
  endtask

  task automatic test_single_bad_code();
    bad[1] = 4'b0100;
    run_and_check(1, -1, "bad_code2");
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 2; d++) begin
        bad[d] = NCODE'($urandom);
        run_and_check(d, -1, $sformatf("random%0d_dut%0d", r, d));
      end
    end
  endtask

  task automatic test_back_to_back();
    bad[0] = NCODE'($urandom);
    run_and_check(0, 5, "restart_ignored");
  endtask

  task automatic test_start_at_done();
    bit got;
    bad[0] = '0;
    start[0] = 1'b1;
    @(negedge sys_clk);
    start[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done[0]) got = 1'b1;
      else @(negedge sys_clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL start_at_done wait_done: got no done within 40 cycles want one");
    end
    start[0] = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_at_done not_accepted: busy got %b want 0", busy[0]);
    end
    @(negedge sys_clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_at_done accepted_next: busy got %b want 1", busy[0]);
    end
    start[0] = 1'b0;
    abort[0] = 1'b1;
    @(negedge sys_clk);
    abort[0] = 1'b0;
    checks++;
    if ({busy[0], done[0], a[0]} !== '0) begin
      errors++;
      $display("FAIL start_at_done abort: busy=%b done=%b a=%0d want all 0", busy[0], done[0], a[0]);
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_abort();
    bit got, stray;
    bad[0] = 4'b0001;
    start[0] = 1'b1;
    @(negedge sys_clk);
    start[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (a[0] == 2'd1) got = 1'b1;
      else @(negedge sys_clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL abort wait_a1: got a=%0d want 1 within 20 cycles", a[0]);
    end
    abort[0] = 1'b1;
    @(negedge sys_clk);
    abort[0] = 1'b0;
    checks++;
    if ({busy[0], a[0], done[0]} !== '0) begin
      errors++;
      $display("FAIL abort next_cycle: busy=%b a=%0d done=%b want 0 0 0", busy[0], a[0], done[0]);
    end
    checks++;
    if (err_cnt[0] !== 8'd1 || fev[0] !== 1'b1 || fec[0] !== 2'd0 || pass[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort frozen: err=%0d fev=%b fec=%0d pass=%b want 1 1 0 0",
               err_cnt[0], fev[0], fec[0], pass[0]);
    end
    stray = 1'b0;
    repeat (8) begin
      @(negedge sys_clk);
      if (done[0] || busy[0]) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL abort no_done: got done/busy after abort want none");
    end
    bad[0] = '0;
    run_and_check(0, -1, "after_abort");
  endtask

  task automatic test_async_reset();
    bad[0] = 4'b1010;
    start[0] = 1'b1;
    @(negedge sys_clk);
    start[0] = 1'b0;
    repeat (7) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({a, busy, check_res, done, pass, err_cnt, fev, fec} !== '0) begin
      errors++;
      $display("FAIL async_reset immediate: busy=%b a0=%0d err0=%0d fev=%b want all 0",
               busy, a[0], err_cnt[0], fev);
    end
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    begin
      bit stray;
      stray = 1'b0;
      repeat (5) begin
        @(negedge sys_clk);
        if (busy !== 2'b00 || a[0] !== 2'd0) stray = 1'b1;
      end
      checks++;
      if (stray) begin
        errors++;
        $display("FAIL async_reset idle: got activity after release want idle until start");
      end
    end
    bad[0] = '0;
    run_and_check(0, -1, "after_reset");
  endtask

  task automatic test_saturate();
    bad[1] = 4'b1111;
    run_and_check(1, -1, "saturate");
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    test_reset();
    test_clean_sweep();
    test_single_bad_code();
    test_back_to_back();
    test_start_at_done();
    test_abort();
    test_async_reset();
    test_saturate();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
